led_breath_ctrl: RTL and testbench
==================================

LED_BREATH_CTRL -- requirements
Module: led_breath_ctrl

Interface
REQ-001 Parameter DIV, default 390625, clock cycles per step tick; legal range 2..2^20-1.
REQ-002 Parameter STEP, default 1, level increment/decrement per tick; legal range 1..255.
REQ-003 Parameter HOLD_TICKS, default 64, ticks spent at each plateau; legal range 1..255.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  single-cycle request to begin breathing.
REQ-007 stop  input  1  single-cycle request to end breathing gracefully.
REQ-008 led_level  output  8  duty value driven to the downstream RGB PWM stage's led_in.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle pulse when a breath period completes or a stop completes.
REQ-011 breath_cnt  output  8  count of completed breath periods.

Function
REQ-012 States SHALL be IDLE, RISE, HOLD_HI, FALL and HOLD_LO; the internal level register is 8-bit unsigned.
REQ-013 The prescaler SHALL count 0..DIV-1 while busy, be held at 0 in IDLE, and raise tick for one clk when it equals DIV-1.
REQ-014 In IDLE, start SHALL move the FSM to RISE with level=0 and prescaler=0; the first tick occurs DIV clocks later.
REQ-015 In RISE, each tick SHALL set level=min(level+STEP,255); on reaching 255 the FSM moves to HOLD_HI with hold counter=0.
REQ-016 In HOLD_HI and HOLD_LO, the hold counter SHALL increment per tick; after HOLD_TICKS ticks the FSM leaves the plateau.
REQ-017 HOLD_HI SHALL exit to FALL.
REQ-018 In FALL, each tick SHALL set level to level-STEP, or to 0 if level<STEP; on reaching 0 the FSM moves to HOLD_LO, or to IDLE if a stop is pending.
REQ-019 On entry to HOLD_LO, done SHALL pulse and breath_cnt SHALL increment, wrapping 255->0.
REQ-020 HOLD_LO SHALL exit to RISE, or to IDLE if a stop is pending.
REQ-021 A stop accepted in RISE or HOLD_HI SHALL set stop-pending and force an immediate transition to FALL; the level continues from its current value, with no jump.
REQ-022 A stop accepted in FALL or HOLD_LO SHALL set stop-pending only.
REQ-023 When a stop completes by entering IDLE, done SHALL pulse, breath_cnt SHALL NOT increment, and stop-pending SHALL clear.
REQ-024 start while busy SHALL be ignored, and stop in IDLE SHALL be ignored.
REQ-025 When start and stop occur in the same cycle, stop SHALL win: in IDLE there is no action, and while busy stop is handled as above.
REQ-026 led_level SHALL be registered, updating exactly one clk after the internal level changes.

Reset
REQ-027 On rst_n low, the block SHALL immediately clear the FSM (to IDLE), level, prescaler, hold counter, stop-pending, led_level, breath_cnt, busy and done, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL abandon the breath with no done pulse.
REQ-029 After rst_n rises, the block SHALL require a new start.

Configuration
REQ-030 With macro LED_BREATH_GAMMA_EN defined, led_level SHALL equal (level*level)>>8, so 255 maps to 254, 128 to 64 and 0 to 0, with the same one-clk latency.
REQ-031 Without LED_BREATH_GAMMA_EN, led_level SHALL equal level, and no multiplier SHALL be synthesized.

Verification (DIV=4, STEP=64, HOLD_TICKS=2, gamma off unless stated)
REQ-032 Pulse start from IDLE -> busy=1 next clk; led_level SHALL step through 64,128,192,255 at 4-clk intervals, hold 255 for 8 clks, fall through 191,127,63,0, then pulse done once with breath_cnt=1.
REQ-033 Pulse stop while led_level=128 in RISE -> next tick gives 64, then 0, then IDLE with busy=0, done pulsed once and breath_cnt unchanged.
REQ-034 Pulse start and stop in the same cycle in IDLE -> busy stays 0; pulse start during FALL -> no change in sequence.
REQ-035 Assert rst_n low mid-HOLD_HI -> led_level=0, busy=0 and breath_cnt=0 immediately with no clk edge; done never pulses.
REQ-036 Run 256 uninterrupted breath periods -> breath_cnt wraps to 0 and done pulses 256 times.
REQ-037 With LED_BREATH_GAMMA_EN and STEP=64 -> the rising sequence SHALL be 16,64,144,254.

Source files
------------

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: LED "breathing" envelope generator.
// Ramps an 8-bit level up, holds, ramps down, holds, repeatedly, and
// drives it to the downstream PWM stage on led_level.
// Optional build macro: LED_BREATH_GAMMA_EN (squared-level gamma on led_level).
module led_breath_ctrl #(
  parameter int unsigned DIV        = 390625,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] led_level,
  output logic       busy,
  output logic       done,
  output logic [7:0] breath_cnt
);

  localparam int unsigned PRE_W = 20;
  localparam int unsigned LVL_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [7:0]         hold_q, hold_d;
  logic               pend_q, pend_d;
  logic [LVL_W-1:0]   led_level_q, led_level_d;
  logic [7:0]         breath_cnt_q, breath_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick;
  logic [LVL_W:0]     rise_sum;
  logic [LVL_W-1:0]   rise_lvl;
  logic [LVL_W-1:0]   fall_lvl;
  logic               hold_last;
  logic               stop_any;

  // Step tick, saturating ramp arithmetic and plateau exit condition
  always_comb begin
    tick      = (state_q != IDLE) && (presc_q == PRE_W'(DIV - 1));
    rise_sum  = {1'b0, level_q} + 9'(STEP);
    rise_lvl  = rise_sum[LVL_W] ? 8'hFF : rise_sum[LVL_W-1:0];
    fall_lvl  = (level_q < 8'(STEP)) ? 8'd0 : (level_q - 8'(STEP));
    hold_last = (hold_q == 8'(HOLD_TICKS - 1));
    stop_any  = pend_q | stop;
  end

  // Next-state, level, counters and registered-output computation
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    hold_d       = hold_q;
    pend_d       = pend_q;
    breath_cnt_d = breath_cnt_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          state_d = RISE;
          level_d = 8'd0;
          hold_d  = 8'd0;
          pend_d  = 1'b0;
        end
      end
      RISE: begin
        if (stop) begin
          pend_d  = 1'b1;
          state_d = FALL;
        end else if (tick) begin
          level_d = rise_lvl;
          if (rise_lvl == 8'hFF) begin
            state_d = HOLD_HI;
            hold_d  = 8'd0;
          end
        end
      end
      HOLD_HI: begin
        if (stop) begin
          pend_d  = 1'b1;
          state_d = FALL;
          hold_d  = 8'd0;
        end else if (tick) begin
          if (hold_last) begin
            state_d = FALL;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      FALL: begin
        if (stop) pend_d = 1'b1;
        if (tick) begin
          level_d = fall_lvl;
          if (fall_lvl == 8'd0) begin
            done_d = 1'b1;
            if (stop_any) begin
              state_d = IDLE;
              pend_d  = 1'b0;
            end else begin
              state_d      = HOLD_LO;
              hold_d       = 8'd0;
              breath_cnt_d = breath_cnt_q + 8'd1;
            end
          end
        end
      end
      HOLD_LO: begin
        if (stop) pend_d = 1'b1;
        if (tick) begin
          if (hold_last) begin
            hold_d = 8'd0;
            if (stop_any) begin
              state_d = IDLE;
              pend_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RISE;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 8'd0;
        hold_d  = 8'd0;
        pend_d  = 1'b0;
      end
    endcase

    // Prescaler runs only while busy and restarts at every tick or start
    if ((state_q == IDLE) || (state_d == IDLE) || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

`ifdef LED_BREATH_GAMMA_EN
  logic [2*LVL_W-1:0] level_sq;

  // Gamma-corrected output: (level*level)>>8
  always_comb begin
    level_sq    = 16'(level_q) * 16'(level_q);
    led_level_d = level_sq[2*LVL_W-1:LVL_W];
  end
`else
  // Linear output: led_level follows level one clock later
  always_comb begin
    led_level_d = level_q;
  end
`endif

  // All state and output registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      presc_q      <= '0;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      led_level_q  <= '0;
      breath_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      led_level_q  <= led_level_d;
      breath_cnt_q <= breath_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign led_level  = led_level_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign breath_cnt = breath_cnt_q;

endmodule

// File: tb/tb_led_breath_ctrl.sv
// Directed bench for led_breath_ctrl with DIV=4, STEP=64, HOLD_TICKS=2.
// Build with LED_BREATH_GAMMA_EN to check the gamma-mapped sequence.
module tb_led_breath_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] led_level;
  logic       busy;
  logic       done;
  logic [7:0] breath_cnt;

  int checks   = 0;
  int failures = 0;
  int done_pulses = 0;
  int done_mark;

  led_breath_ctrl #(.DIV(4), .STEP(64), .HOLD_TICKS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .led_level  (led_level),
    .busy       (busy),
    .done       (done),
    .breath_cnt (breath_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge
  always @(negedge clk) if (done === 1'b1) done_pulses++;

  // Expected led_level for a given internal level
  function automatic int exp_led(input int lvl);
`ifdef LED_BREATH_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    #12;
    check("rst_led", int'(led_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cnt", int'(breath_cnt), 0);
    rst_n = 1'b1;
    adv(2);
    check("idle_busy", int'(busy), 0);

    // Full breath; start pulse during FALL must be ignored
    start = 1'b1;
    adv(1);                                    // k=0
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_led", int'(led_level), 0);
    adv(4);                                    // k=4
    check("rise0_led_lag", int'(led_level), 0);
    adv(1);                                    // k=5
    check("rise1_led", int'(led_level), exp_led(64));
    adv(4);                                    // k=9
    check("rise2_led", int'(led_level), exp_led(128));
    adv(4);                                    // k=13
    check("rise3_led", int'(led_level), exp_led(192));
    adv(4);                                    // k=17
    check("rise4_led", int'(led_level), exp_led(255));
    adv(11);                                   // k=28
    check("hold_hi_led", int'(led_level), exp_led(255));
    adv(1);                                    // k=29
    check("fall1_led", int'(led_level), exp_led(191));
    start = 1'b1;
    adv(1);                                    // k=30
    start = 1'b0;
    adv(3);                                    // k=33
    check("fall2_led", int'(led_level), exp_led(127));
    check("fall_start_busy", int'(busy), 1);
    adv(4);                                    // k=37
    check("fall3_led", int'(led_level), exp_led(63));
    adv(3);                                    // k=40
    check("breath_done", int'(done), 1);
    check("breath_cnt1", int'(breath_cnt), 1);
    adv(1);                                    // k=41
    check("breath_done_off", int'(done), 0);
    check("hold_lo_led", int'(led_level), 0);
    check("hold_lo_busy", int'(busy), 1);

    // Second breath: stop while led_level shows 128 in RISE
    adv(16);                                   // k=57
    check("rise_b2_led", int'(led_level), exp_led(128));
    stop = 1'b1;
    adv(1);                                    // k=58
    stop = 1'b0;
    adv(2);                                    // k=60
    check("stop_no_jump", int'(led_level), exp_led(128));
    adv(1);                                    // k=61
    check("stop_fall_led", int'(led_level), exp_led(64));
    adv(3);                                    // k=64
    check("stop_done", int'(done), 1);
    check("stop_busy", int'(busy), 0);
    check("stop_cnt", int'(breath_cnt), 1);
    adv(1);                                    // k=65
    check("stop_led0", int'(led_level), 0);
    check("stop_done_off", int'(done), 0);
    check("done_pulses_2", done_pulses, 2);

    // start+stop together in IDLE: nothing happens; stop alone in IDLE ignored
    start = 1'b1;
    stop  = 1'b1;
    adv(1);
    start = 1'b0;
    stop  = 1'b0;
    check("startstop_busy", int'(busy), 0);
    stop = 1'b1;
    adv(1);
    stop = 1'b0;
    adv(6);
    check("idle_stop_busy", int'(busy), 0);
    check("idle_stop_led", int'(led_level), 0);
    check("idle_done_pulses", done_pulses, 2);

    // Asynchronous reset in HOLD_HI
    start = 1'b1;
    adv(1);                                    // k=0
    start = 1'b0;
    adv(20);                                   // k=20, HOLD_HI
    check("pre_rst_led", int'(led_level), exp_led(255));
    done_mark = done_pulses;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led_level), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_cnt", int'(breath_cnt), 0);
    adv(2);
    rst_n = 1'b1;
    adv(20);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_no_done", done_pulses, done_mark);

    // 256 uninterrupted breaths: counter wraps to 0
    done_mark = done_pulses;
    start = 1'b1;
    adv(1);                                    // k=0
    start = 1'b0;
    adv(40);                                   // first done
    check("wrap_done1", int'(done), 1);
    check("wrap_cnt1", int'(breath_cnt), 1);
    adv(48 * 254);
    check("wrap_done255", int'(done), 1);
    check("wrap_cnt255", int'(breath_cnt), 255);
    adv(48);
    check("wrap_done256", int'(done), 1);
    check("wrap_cnt0", int'(breath_cnt), 0);
    adv(1);
    check("wrap_pulses", done_pulses - done_mark, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
